// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, imem request issue, in-order prefetch FIFO to decode.
// Response to instr_valid is one cycle; requests stall when outstanding + buffered reaches DEPTH.

module fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] dat;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc;
  logic [31:0]  rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] stale;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_pc_aligned;
  logic          accept;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          unused_redirect_lsb;

  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit uses registered occupancy only; a same-cycle pop frees credit next cycle.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = rst_n && (credit_used < DEPTH_W);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  // A response arriving in the redirect cycle belongs to the old stream and is dropped.
  assign push = imem_rsp_valid && (stale == '0) && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign push_entry.dat = imem_rsp_data;
  assign push_entry.pc  = rsp_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        pc     <= redirect_pc_aligned;
        rsp_pc <= redirect_pc_aligned;
        stale  <= outstanding_nxt;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (imem_rsp_valid && (stale != '0)) begin
          stale <= stale - CW'(1);
        end
      end
    end
  end

  fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head_entry),
    .count    (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head_entry.dat : NOP;
  assign instr_pc    = instr_valid ? head_entry.pc  : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returning address as data, scoreboard of expected PCs.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        req2_valid;
  logic [31:0] req2_addr;
  logic [31:0] unused_instr2;
  logic [31:0] unused_instr2_pc;
  logic        unused_instr2_valid;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] a2_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          lat;
  int          dcount;
  int          acount;
  int          first_cyc;
  logic [31:0] first_pc;
  bit          first_seen;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  // Second instance only exercises the wrapping reset PC; memory never answers.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (req2_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (req2_addr),
    .imem_rsp_valid (1'b0),
    .imem_rsp_data  (32'h0),
    .instr          (unused_instr2),
    .instr_pc       (unused_instr2_pc),
    .instr_valid    (unused_instr2_valid),
    .instr_ready    (1'b0),
    .redirect       (1'b0),
    .redirect_pc    (32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    dcount     = 0;
    acount     = 0;
    first_seen = 1'b0;
    first_cyc  = 0;
    first_pc   = 32'h0;
  endtask

  // Evaluates the handshakes of the current cycle mid-cycle, then advances to just after the edge.
  task automatic cycle();
    mreq_t       m;
    logic [31:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (instr_valid && instr_ready && !redirect) begin
        dcount++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
          first_pc   = instr_pc;
        end
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_delivery: observed pc %h expected no instruction", instr_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("deliver_pc", instr_pc, e);
          chk("deliver_instr", instr, e);
        end
      end
      if (imem_rsp_valid && mem_q.size() != 0) begin
        m = mem_q.pop_front();
      end
      if (imem_req_valid && imem_req_ready) begin
        acount++;
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        if (!redirect) exp_q.push_back(imem_req_addr);
      end
      if (redirect) exp_q.delete();
      if (req2_valid) a2_q.push_back(req2_addr);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset(input bit check_async);
    rst_n = 1'b0;
    #1;
    if (check_async) chk("rst_async_instr_valid", {31'b0, instr_valid}, 32'd0);
    mem_q.delete();
    exp_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect       = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_wrap_addr", req2_addr, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 1;
    mark();
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    lat            = 1;
    cyc            = 0;
    mark();

    // Streaming from reset with 1-cycle memory.
    do_reset(1'b0);
    #3;
    chk("t1_c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_c1_req_addr", imem_req_addr, 32'h0);
    repeat (12) cycle();
    chk("t1_first_valid_cyc", first_cyc, 3);
    chk("t1_deliveries", dcount, 10);
    chk("t5_wrap_count", a2_q.size(), 4);
    if (a2_q.size() == 4) begin
      chk("t5_wrap_pc0", a2_q[0], 32'hFFFF_FFF8);
      chk("t5_wrap_pc1", a2_q[1], 32'hFFFF_FFFC);
      chk("t5_wrap_pc2", a2_q[2], 32'h0000_0000);
      chk("t5_wrap_pc3", a2_q[3], 32'h0000_0004);
    end

    // Decode stalled: FIFO fills to DEPTH, then drains in order.
    instr_ready = 1'b0;
    do_reset(1'b1);
    repeat (10) cycle();
    chk("t2_accepts", acount, 4);
    chk("t2_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    repeat (8) cycle();
    chk("t2_deliveries", dcount, 8);

    // Memory stall with a misaligned redirect in the middle.
    imem_req_ready = 1'b0;
    do_reset(1'b0);
    #3;
    chk("t3_addr_c1", imem_req_addr, 32'h0);
    cycle();
    #3;
    chk("t3_addr_hold", imem_req_addr, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0101;
    cycle();
    redirect = 1'b0;
    #3;
    chk("t3_addr_redirect", imem_req_addr, 32'h0000_0100);
    chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    cycle();
    imem_req_ready = 1'b1;
    repeat (6) cycle();
    chk("t3_first_pc", first_pc, 32'h0000_0100);
    chk("t3_first_cyc", first_cyc, 6);

    // Redirect with two in flight and two buffered, 3-cycle memory.
    lat         = 3;
    instr_ready = 1'b0;
    do_reset(1'b0);
    repeat (5) cycle();
    #3;
    chk("t4_full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t4_head_pc", instr_pc, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    instr_ready = 1'b1;
    cycle();
    redirect = 1'b0;
    #3;
    chk("t4_flushed", {31'b0, instr_valid}, 32'd0);
    chk("t4_new_addr", imem_req_addr, 32'h0000_0200);
    mark();
    repeat (8) cycle();
    chk("t4_first_pc", first_pc, 32'h0000_0200);
    chk("t4_first_cyc", first_cyc, 11);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    do_reset(1'b0);
    repeat (5) cycle();
    #3;
    chk("t6_pre_valid", {31'b0, instr_valid}, 32'd1);
    chk("t6_pre_rsp", {31'b0, imem_rsp_valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    #3;
    chk("t6_empty_after", {31'b0, instr_valid}, 32'd0);
    mark();
    repeat (6) cycle();
    chk("t6_first_pc", first_pc, 32'h0000_0300);
    chk("t6_first_cyc", first_cyc, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
